// File: rtl/button_debouncer.sv
// Per-channel synchronizer + debouncer producing clean levels and one-cycle press/release pulses.
// Define BUTTON_ACTIVE_LOW_EN to invert every raw pin (pin low = pressed).
module button_debouncer #(
  parameter int unsigned NUM_BUTTONS     = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 742500
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [NUM_BUTTONS-1:0] raw_in,
  output logic [NUM_BUTTONS-1:0] level_out,
  output logic [NUM_BUTTONS-1:0] press_pulse_out,
  output logic [NUM_BUTTONS-1:0] release_pulse_out
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StStableLow,
    StWaitHigh,
    StStableHigh,
    StWaitLow
  } state_e;

  logic [NUM_BUTTONS-1:0] raw_cond;

`ifdef BUTTON_ACTIVE_LOW_EN
  assign raw_cond = ~raw_in;
`else
  assign raw_cond = raw_in;
`endif

  logic [SYNC_STAGES-1:0][NUM_BUTTONS-1:0] sync_q, sync_d;
  logic [NUM_BUTTONS-1:0]                  s;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_cond};
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
        state_q   <= StStableLow;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Any disagreeing sample during a wait drops back to the stable state, restarting the count.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StStableLow: begin
          if (s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = StStableHigh;
            end else begin
              state_d = StWaitHigh;
              cnt_d   = CntOne;
            end
          end
        end
        StWaitHigh: begin
          if (!s[i]) begin
            state_d = StStableLow;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StStableHigh;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStableHigh: begin
          if (!s[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = StStableLow;
            end else begin
              state_d = StWaitLow;
              cnt_d   = CntOne;
            end
          end
        end
        StWaitLow: begin
          if (s[i]) begin
            state_d = StStableHigh;
            cnt_d   = '0;
          end else if (cnt_q == CntLast) begin
            state_d = StStableLow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        default: begin
          state_d = StStableLow;
          cnt_d   = '0;
        end
      endcase
    end

    // level_q always tracks the current state, so edges of the next level give the pulses.
    always_comb begin
      level_d   = (state_d == StStableHigh) || (state_d == StWaitLow);
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
    end

    assign level_out[i]         = level_q;
    assign press_pulse_out[i]   = press_q;
    assign release_pulse_out[i] = release_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: per-edge vector table plus hand-written reset sequences.
// Vectors use logical pressed values; BUTTON_ACTIVE_LOW_EN flips the physical pin drive.
module tb_button_debouncer;

  localparam int unsigned NB = 5;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] raw_in;
  logic [NB-1:0] level_out;
  logic [NB-1:0] press_pulse_out;
  logic [NB-1:0] release_pulse_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  button_debouncer #(
    .NUM_BUTTONS    (NB),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in           (clk),
    .reset_n_in       (reset_n),
    .raw_in           (raw_in),
    .level_out        (level_out),
    .press_pulse_out  (press_pulse_out),
    .release_pulse_out(release_pulse_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] phys(input logic [NB-1:0] l);
`ifdef BUTTON_ACTIVE_LOW_EN
    return ~l;
`else
    return l;
`endif
  endfunction

  task automatic check(input string name, input int idx, input logic [NB-1:0] el,
                       input logic [NB-1:0] ep, input logic [NB-1:0] er);
    checks++;
    if ({level_out, press_pulse_out, release_pulse_out} !== {el, ep, er}) begin
      failures++;
      $display("FAIL %s[%0d]: lvl/press/rel got %b/%b/%b want %b/%b/%b", name, idx,
               level_out, press_pulse_out, release_pulse_out, el, ep, er);
    end
  endtask

  // Called at a negedge: drive raw, take one edge, check at the following negedge.
  task automatic step(input string name, input int idx, input logic [NB-1:0] raw,
                      input logic [NB-1:0] el, input logic [NB-1:0] ep,
                      input logic [NB-1:0] er);
    raw_in = phys(raw);
    @(posedge clk);
    @(negedge clk);
    check(name, idx, el, ep, er);
  endtask

  // n edges with raw held; pulses (and the level change) land on edge 'at' (0 = none).
  task automatic add_phase(input logic [NB-1:0] raw, input int n, input logic [NB-1:0] lpre,
                           input logic [NB-1:0] lpost, input logic [NB-1:0] prs,
                           input logic [NB-1:0] rel, input int at);
    vec_t v;
    for (int k = 1; k <= n; k++) begin
      v.raw = raw;
      v.lvl = (at != 0 && k >= at) ? lpost : lpre;
      v.prs = (k == at) ? prs : '0;
      v.rel = (k == at) ? rel : '0;
      vecs.push_back(v);
    end
  endtask

  initial begin
    // Clean press on ch0: edge 6 raises level and pulses, edge 7 drops the pulse.
    add_phase(5'b00001, 7, 5'b00000, 5'b00001, 5'b00001, 5'b00000, 6);
    // Bounce on ch1: 3 high, 1 low, then 10 high; one press 6 edges after the final rise.
    add_phase(5'b00011, 3, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0);
    add_phase(5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 0);
    add_phase(5'b00011, 10, 5'b00001, 5'b00011, 5'b00010, 5'b00000, 6);
    // Press ch2, 2-cycle low glitch (rejected), then sustained low releases.
    add_phase(5'b00111, 7, 5'b00011, 5'b00111, 5'b00100, 5'b00000, 6);
    add_phase(5'b00011, 2, 5'b00111, 5'b00111, 5'b00000, 5'b00000, 0);
    add_phase(5'b00111, 6, 5'b00111, 5'b00111, 5'b00000, 5'b00000, 0);
    add_phase(5'b00011, 7, 5'b00111, 5'b00011, 5'b00000, 5'b00100, 6);
    // Release two channels at once, then a simultaneous press on 10101.
    add_phase(5'b00000, 7, 5'b00011, 5'b00000, 5'b00000, 5'b00011, 6);
    add_phase(5'b10101, 7, 5'b00000, 5'b10101, 5'b10101, 5'b00000, 6);
    // ch3 high for exactly DEBOUNCE_CYCLES samples: accepted, then released.
    add_phase(5'b11101, 4, 5'b10101, 5'b10101, 5'b00000, 5'b00000, 0);
    add_phase(5'b10101, 3, 5'b10101, 5'b11101, 5'b01000, 5'b00000, 2);
    add_phase(5'b10101, 5, 5'b11101, 5'b10101, 5'b00000, 5'b01000, 3);

    reset_n = 1'b0;
    raw_in  = phys(5'b00000);
    repeat (3) @(negedge clk);
    check("idle_reset", 0, 5'b00000, 5'b00000, 5'b00000);
    reset_n = 1'b1;
    step("idle_after_reset", 0, 5'b00000, 5'b00000, 5'b00000, 5'b00000);

    foreach (vecs[i]) begin
      step("vec", i, vecs[i].raw, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
    end

    // Reset arriving at edge 4 of a ch1 press aborts it with no pulse.
    for (int k = 1; k <= 3; k++) begin
      step("midcount_pre", k, 5'b10111, 5'b10101, 5'b00000, 5'b00000);
    end
    reset_n = 1'b0;
    #1;
    check("midcount_async", 0, 5'b00000, 5'b00000, 5'b00000);
    raw_in = phys(5'b00000);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("midcount_hold", k, 5'b00000, 5'b00000, 5'b00000);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step("midcount_post", k, 5'b00000, 5'b00000, 5'b00000, 5'b00000);
    end

    // All buttons held through reset: outputs stay 0, then a normal press at edge 6.
    reset_n = 1'b0;
    raw_in  = phys(5'b11111);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("held_reset", k, 5'b00000, 5'b00000, 5'b00000);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step("held_release", k, 5'b11111, (k >= 6) ? 5'b11111 : 5'b00000,
           (k == 6) ? 5'b11111 : 5'b00000, 5'b00000);
    end
    for (int k = 1; k <= 7; k++) begin
      step("all_release", k, 5'b00000, (k >= 6) ? 5'b00000 : 5'b11111, 5'b00000,
           (k == 6) ? 5'b11111 : 5'b00000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
